alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  EX-stage issue unit that produces the ALU's inputs. It decodes ALUOp/funct into the
//  3-bit ALU control code and registers it with operands a/b. A 2-entry skid buffer
//  absorbs ALU-side backpressure. Sits between the ID/EX register and the ALU.
// PARAMETERS
//  WIDTH    32  operand width (a, b)
// PORTS  (one clock; reset is synchronous and active-high)
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous active-high reset
//  flush       in   1      kill all buffered ops (branch mispredict)
//  in_valid    in   1      upstream op present
//  in_ready    out  1      buffer can accept (registered; = entry1 empty)
//  alu_op      in   2      00 add (lw/sw), 01 sub (beq), 10 use funct, 11 reserved
//  funct       in   6      R-type funct field
//  in_a        in   WIDTH  operand a
//  in_b        in   WIDTH  operand b
//  out_valid   out  1      op presented to ALU
//  out_ready   in   1      ALU/EX consumes op this cycle
//  control     out  3      ALU code: 010 add,110 sub,000 and,001 or,111 slt
//  a           out  WIDTH  operand a to ALU
//  b           out  WIDTH  operand b to ALU
//  illegal     out  1      current output op undecodable (ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  - Decode: funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
//    Any other funct with alu_op=10, or alu_op=11, is undecodable.
//  - Transfers: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
//  - Storage: entry0 (output register) and entry1 (skid). Outputs driven from entry0 only.
//  - Latency: op accepted at edge N is visible at the outputs after edge N (1 cycle).
//  - Cases each edge:
//      entry0 empty or out_fire, entry1 empty: entry0<=input if in_fire, else empty.
//      entry0 empty or out_fire, entry1 full : entry0<=entry1; entry1<=input if in_fire.
//      entry0 full, no out_fire              : entry1<=input if in_fire (only when empty).
//  - Order preserved; no op dropped or duplicated; full throughput (1 op/cycle) when
//    out_ready is held high.
//  - in_ready = !entry1_full, registered. in_valid while in_ready=0 is ignored
//    (upstream must hold the op).
//  - flush: both entries invalid next cycle. An in_fire in the same cycle is also
//    discarded. flush wins over out_fire and in_fire.
//  - reset (any time, incl. mid-transfer): out_valid=0, in_ready=1, control=3'b010,
//    a=0, b=0, illegal=0, both entries empty.
//  - When out_valid=0, control/a/b hold their last value (don't-care to the ALU).
//  - Operands pass unmodified; no arithmetic is performed here.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN defined: an undecodable op is issued with control=3'b010 and
//    illegal=1 alongside out_valid.
//  ALU_ILLEGAL_TRAP_EN undefined: the illegal port is tied 0. An undecodable op is issued
//    with control=3'b010 (add), silently.
// STRUCTURE
//  - Shared package alu_pkg: ALU code localparams (ALU_ADD/SUB/AND/OR/SLT), ALUOp
//    encodings, funct constants, and the typedef for an issue entry
//    {ctrl[2:0], illegal, a, b}.
//  - One sub-module: alu_ctrl_decode (combinational alu_op/funct -> ctrl, illegal).
//    This module adds the skid buffer and handshake.
// TESTING
//  1 reset high 2 cycles mid-stream -> out_valid=0, in_ready=1, control=010, a=b=0.
//  2 alu_op=10, funct=101010, in_a=5, in_b=9, out_ready=1 -> next cycle out_valid=1,
//    control=111, a=5, b=9.
//  3 out_ready=1 throughout, ops add/sub/and/or back-to-back -> one op per cycle,
//    controls 010,110,000,001 in order.
//  4 out_ready=0; send 3 ops -> first two held, in_ready=0 after 2nd. Raise out_ready ->
//    drains in order; third is accepted only after in_ready returns 1.
//  5 two ops buffered, then flush together with in_valid -> next cycle out_valid=0,
//    in_ready=1, and no op emerges later.
//  6 alu_op=11 -> control=010; illegal=1 with the macro defined, 0 without.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes, ALUOp and funct encodings,
// and the issue-entry record carried through the skid buffer.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic [2:0]           ctrl;
        logic                 illegal;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } issue_entry_t;

    localparam issue_entry_t ENTRY_RESET = '{
        ctrl:    ALU_ADD,
        illegal: 1'b0,
        a:       '0,
        b:       '0
    };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALU control decoder. Undecodable ops fall back to add;
// they are flagged on o_illegal only when ALU_ILLEGAL_TRAP_EN is defined.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_ctrl,
    output logic       o_illegal
);

`ifdef ALU_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_ctrl    = ALU_ADD;
        o_illegal = 1'b0;
        unique case (i_alu_op)
            ALUOP_ADD: o_ctrl = ALU_ADD;
            ALUOP_SUB: o_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_ctrl = ALU_ADD;
                    FUNCT_SUB: o_ctrl = ALU_SUB;
                    FUNCT_AND: o_ctrl = ALU_AND;
                    FUNCT_OR:  o_ctrl = ALU_OR;
                    FUNCT_SLT: o_ctrl = ALU_SLT;
                    default:   o_illegal = TRAP_EN;
                endcase
            end
            ALUOP_RSVD: o_illegal = TRAP_EN;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// EX-stage issue unit: decodes the op, then queues it in a 2-entry skid buffer ahead
// of the ALU. Illegal-op flagging is enabled by defining ALU_ILLEGAL_TRAP_EN.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       control,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             illegal
);

    issue_entry_t r_e0;
    issue_entry_t r_e1;
    logic         r_e0_valid;
    logic         r_e1_valid;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_e0_free;
    logic [2:0]   w_dec_ctrl;
    logic         w_dec_illegal;
    issue_entry_t w_in_entry;

    alu_ctrl_decode u_decode (
        .i_alu_op  (alu_op),
        .i_funct   (funct),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    assign w_in_entry = '{ctrl: w_dec_ctrl, illegal: w_dec_illegal, a: in_a, b: in_b};

    // in_ready comes straight from the entry1 flop, so it is registered by construction.
    assign in_ready   = !r_e1_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_e0_valid && out_ready;
    assign w_e0_free  = !r_e0_valid || w_out_fire;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_e0_valid <= 1'b0;
            r_e1_valid <= 1'b0;
            r_e0       <= ENTRY_RESET;
        end else if (flush) begin
            r_e0_valid <= 1'b0;
            r_e1_valid <= 1'b0;
        end else if (w_e0_free) begin
            if (r_e1_valid) begin
                r_e0       <= r_e1;
                r_e0_valid <= 1'b1;
                r_e1_valid <= w_in_fire;
            end else begin
                r_e0_valid <= w_in_fire;
                if (w_in_fire) r_e0 <= w_in_entry;
            end
        end else if (w_in_fire) begin
            r_e1_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload is never reset; its valid flag alone decides whether it is read.
    always_ff @(posedge clk) begin
        if (w_in_fire && (r_e1_valid || !w_e0_free)) begin
            r_e1 <= w_in_entry;
        end
    end

    assign out_valid = r_e0_valid;
    assign control   = r_e0.ctrl;
    assign a         = r_e0.a;
    assign b         = r_e0.b;
    assign illegal   = r_e0_valid && r_e0.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed scenarios plus a randomized run
// against a queue-based reference model. Honours ALU_ILLEGAL_TRAP_EN if defined.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;

    int n_pass = 0;
    int n_total = 0;

`ifdef ALU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [2:0]  ctrl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t q[$];

    always #5 clk = ~clk;

    alu_ctrl_issue #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .control   (control),
        .a         (a),
        .b         (b),
        .illegal   (illegal)
    );

    // What the ALU should see for an op, straight from the decode table.
    function automatic op_t ref_op(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] ia, input logic [31:0] ib);
        op_t r;
        r.a = ia;
        r.b = ib;
        r.ctrl = 3'b010;
        r.ill = 1'b0;
        if (op == 2'b00) r.ctrl = 3'b010;
        else if (op == 2'b01) r.ctrl = 3'b110;
        else if (op == 2'b11) r.ill = TRAP;
        else if (f == 6'd32) r.ctrl = 3'b010;
        else if (f == 6'd34) r.ctrl = 3'b110;
        else if (f == 6'd36) r.ctrl = 3'b000;
        else if (f == 6'd37) r.ctrl = 3'b001;
        else if (f == 6'd42) r.ctrl = 3'b111;
        else r.ill = TRAP;
        return r;
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] ia, input logic [31:0] ib, input logic ordy);
        bit m_out_valid;
        bit m_in_ready;
        reset = rst; flush = fl; in_valid = iv; alu_op = op; funct = f;
        in_a = ia; in_b = ib; out_ready = ordy;
        m_out_valid = (q.size() > 0);
        m_in_ready  = (q.size() < 2);
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
        end else begin
            if (m_out_valid && ordy) void'(q.pop_front());
            if (iv && m_in_ready) q.push_back(ref_op(op, f, ia, ib));
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, ordy);
    endtask

    task automatic test_reset;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b01, 6'd0, 32'h11, 32'h22, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 32'h33, 32'h44, 1'b0);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_prefill: in_ready got %b want 0", in_ready);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b1, 2'b01, 6'd0, 32'h55, 32'h66, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 2'b01, 6'd0, 32'h55, 32'h66, 1'b1);
        n_total++;
        if ({out_valid, in_ready, control, a, b, illegal} !== {1'b0, 1'b1, 3'b010, 32'd0, 32'd0, 1'b0})
            $display("FAIL reset_state: got v=%b r=%b c=%b a=%0h b=%0h i=%b want v=0 r=1 c=010 a=0 b=0 i=0",
                     out_valid, in_ready, control, a, b, illegal);
        else n_pass++;
    endtask

    task automatic test_slt;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 6'b101010, 32'd5, 32'd9, 1'b1);
        n_total++;
        if ({out_valid, control, a, b} !== {1'b1, 3'b111, 32'd5, 32'd9})
            $display("FAIL slt_issue: got v=%b c=%b a=%0d b=%0d want v=1 c=111 a=5 b=9",
                     out_valid, control, a, b);
        else n_pass++;
        idle(1'b1);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL slt_drain: out_valid got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] fs[4];
        logic [2:0] cs[4];
        fs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
        cs = '{3'b010, 3'b110, 3'b000, 3'b001};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 2'b10, fs[i], 32'(100 + i), 32'(200 + i), 1'b1);
            n_total++;
            if ({out_valid, in_ready, control, a} !== {1'b1, 1'b1, cs[i], 32'(100 + i)})
                $display("FAIL b2b_op%0d: got v=%b r=%b c=%b a=%0d want v=1 r=1 c=%b a=%0d",
                         i, out_valid, in_ready, control, a, cs[i], 100 + i);
            else n_pass++;
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 32'd1, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b01, 6'd0, 32'd2, 32'd0, 1'b0);
        n_total++;
        if ({out_valid, in_ready, a} !== {1'b1, 1'b0, 32'd1})
            $display("FAIL bp_full: got v=%b r=%b a=%0d want v=1 r=0 a=1", out_valid, in_ready, a);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 6'b100100, 32'd3, 32'd0, 1'b0);
        n_total++;
        if ({in_ready, a, control} !== {1'b0, 32'd1, 3'b010})
            $display("FAIL bp_hold: got r=%b a=%0d c=%b want r=0 a=1 c=010", in_ready, a, control);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 6'b100100, 32'd3, 32'd0, 1'b1);
        n_total++;
        if ({out_valid, in_ready, a, control} !== {1'b1, 1'b1, 32'd2, 3'b110})
            $display("FAIL bp_drain2: got v=%b r=%b a=%0d c=%b want v=1 r=1 a=2 c=110",
                     out_valid, in_ready, a, control);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 6'b100100, 32'd3, 32'd0, 1'b1);
        n_total++;
        if ({out_valid, a, control} !== {1'b1, 32'd3, 3'b000})
            $display("FAIL bp_third: got v=%b a=%0d c=%b want v=1 a=3 c=000", out_valid, a, control);
        else n_pass++;
        idle(1'b1);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty: out_valid got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flush;
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 32'd7, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 6'd0, 32'd8, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 6'd0, 32'd9, 32'd0, 1'b1);
        n_total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL flush_ghost%0d: out_valid got %b want 0", i, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_illegal;
        cycle(1'b0, 1'b0, 1'b1, 2'b11, 6'b100010, 32'd4, 32'd6, 1'b1);
        n_total++;
        if ({out_valid, control, illegal} !== {1'b1, 3'b010, TRAP})
            $display("FAIL illegal_aluop11: got v=%b c=%b i=%b want v=1 c=010 i=%b",
                     out_valid, control, illegal, TRAP);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 6'b000111, 32'd4, 32'd6, 1'b1);
        n_total++;
        if ({out_valid, control, illegal} !== {1'b1, 3'b010, TRAP})
            $display("FAIL illegal_funct: got v=%b c=%b i=%b want v=1 c=010 i=%b",
                     out_valid, control, illegal, TRAP);
        else n_pass++;
        idle(1'b1);
        n_total++;
        if (illegal !== 1'b0) $display("FAIL illegal_idle: illegal got %b want 0", illegal);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [5:0] ftab[5];
        ftab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 600; i++) begin
            logic       rst, fl, iv, ordy;
            logic [1:0] op;
            logic [5:0] f;
            int         k;
            rst  = ($urandom_range(0, 79) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 1) == 1);
            op   = 2'($urandom_range(0, 3));
            k    = $urandom_range(0, 5);
            f    = (k == 5) ? 6'($urandom) : ftab[k];
            cycle(rst, fl, iv, op, f, $urandom, $urandom, ordy);
            n_total++;
            if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2})
                $display("FAIL rand_hs[%0d]: got v=%b r=%b want v=%b r=%b",
                         i, out_valid, in_ready, q.size() > 0, q.size() < 2);
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({control, illegal, a, b} !== {q[0].ctrl, q[0].ill, q[0].a, q[0].b})
                    $display("FAIL rand_data[%0d]: got c=%b i=%b a=%0h b=%0h want c=%b i=%b a=%0h b=%0h",
                             i, control, illegal, a, b, q[0].ctrl, q[0].ill, q[0].a, q[0].b);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_slt();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
